// File: rtl/seg7_scan_driver_pkg.sv
// Shared types, segment patterns and the nibble encoder for the seven-segment scan driver.
// Patterns are active-high. Polarity inversion is done at the top level.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_e;

    localparam seg_t SEG_0    = 8'h3F;
    localparam seg_t SEG_1    = 8'h06;
    localparam seg_t SEG_2    = 8'h5B;
    localparam seg_t SEG_3    = 8'h4F;
    localparam seg_t SEG_4    = 8'h66;
    localparam seg_t SEG_5    = 8'h6D;
    localparam seg_t SEG_6    = 8'h7D;
    localparam seg_t SEG_7    = 8'h07;
    localparam seg_t SEG_8    = 8'h7F;
    localparam seg_t SEG_9    = 8'h6F;
    localparam seg_t SEG_DASH = 8'h40;
    localparam seg_t SEG_OFF  = 8'h00;

    function automatic seg_t seg7_encode(input logic [3:0] nibble, input logic dp);
        seg_t s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        s[7] = dp;
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data/display bundle between the BCD source (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 6
);
    import seg7_pkg::*;

    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    bcd_valid;
    logic [NUM_DIGITS-1:0]   dp_in;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   digit_cs;
    logic                    frame_done;

    modport master (
        output bcd_in, bcd_valid, dp_in,
        input  seg, digit_cs, frame_done
    );

    modport slave (
        input  bcd_in, bcd_valid, dp_in,
        output seg, digit_cs, frame_done
    );

endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational nibble/dp/blank to active-high segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = seg7_encode(nibble_i, dp_i);
        // A blanked digit keeps its decimal point.
        if (blank_i) begin
            seg_o    = SEG_OFF;
            seg_o[7] = dp_i;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow capture and blank gap per slot.
// Optional leading-zero blanking: define SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int CS_ACTIVE_LOW  = 1
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam seg_t SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] CS_IDLE = (CS_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   cs_q, cs_d;
    logic                    frame_done_q, frame_done_d;

    logic [4*NUM_DIGITS-1:0] upper;
    logic                    dec_blank;
    seg_t                    dec_seg;
    logic                    wrap;
    phase_e                  phase_d;
    logic [NUM_DIGITS-1:0]   onehot;

    // Nibble at digit_idx sits in upper[3:0]; an all-zero upper means this and every higher digit is zero.
    assign upper = shadow_bcd_q >> {digit_idx_q, 2'b00};

`ifdef SEG7_LZB_EN
    assign dec_blank = (digit_idx_q != '0) && (upper == '0);
`else
    assign dec_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .nibble_i (upper[3:0]),
        .dp_i     (shadow_dp_q[digit_idx_q]),
        .blank_i  (dec_blank),
        .seg_o    (dec_seg)
    );

    always_comb begin
        div_cnt_d    = div_cnt_q;
        digit_idx_d  = digit_idx_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        seg_d        = seg_q;
        cs_d         = CS_IDLE;
        frame_done_d = 1'b0;
        onehot       = '0;
        phase_d      = PH_BLANK;

        if (bus.bcd_valid) begin
            shadow_bcd_d = bus.bcd_in;
            shadow_dp_d  = bus.dp_in;
        end

        wrap = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
        if (wrap) begin
            div_cnt_d    = '0;
            digit_idx_d  = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
            frame_done_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // Segments latch from the pre-edge shadow, so a same-edge capture lands one slot later.
        if (div_cnt_q == '0) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~dec_seg : dec_seg;
        end

        // Outputs are registered, so the phase is judged on the count the edge produces.
        if (div_cnt_d >= CNT_W'(BLANK_CYCLES)) begin
            phase_d = PH_ON;
        end
        if (phase_d == PH_ON) begin
            onehot[digit_idx_d] = 1'b1;
            cs_d = (CS_ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= SEG_IDLE;
            cs_q         <= CS_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            cs_q         <= cs_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.digit_cs   = cs_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (6 digits, 4 clocks/slot, 1 blank clock).
// Honours SEG7_LZB_EN in its reference model.
module tb_seg7_scan_driver;

    localparam int ND   = 6;
    localparam int DIV  = 4;
    localparam int FRM  = ND * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (DIV),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (0),
        .CS_ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n        = 0;      // posedges since reset release
    logic [23:0] m_bcd    = '0;
    logic [5:0]  m_dp     = '0;
    logic [7:0]  m_seg    = '0;
    logic [7:0]  digits [16];

    function automatic logic [7:0] ref_seg(input logic [23:0] bcd, input logic [5:0] dp, input int idx);
        logic [23:0] up;
        logic [3:0]  nib;
        logic [7:0]  pat;
        up  = bcd >> (4 * idx);
        nib = up[3:0];
        pat = digits[nib];
`ifdef SEG7_LZB_EN
        if (idx > 0 && up == 24'h0) pat = 8'h00;
`endif
        if (dp[idx]) pat = pat | 8'h80;
        return pat;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h at n=%0d", tag, got, exp, n);
        end
    endtask

    task automatic check_outputs();
        logic [5:0] cs;
        cs = 6'h3F;
        if (n % DIV >= 1) begin
            cs = 6'b1 << ((n / DIV) % ND);
            cs = ~cs;
        end
        chk("seg", bus.seg, m_seg);
        chk("digit_cs", {2'b00, bus.digit_cs}, {2'b00, cs});
        chk("frame_done", {7'b0, bus.frame_done}, {7'b0, (n > 0 && n % FRM == 0)});
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        if ((n - 1) % DIV == 0) m_seg = ref_seg(m_bcd, m_dp, ((n - 1) / DIV) % ND);
        if (bus.bcd_valid) begin
            m_bcd = bus.bcd_in;
            m_dp  = bus.dp_in;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic goto_phase(input int r);
        for (int i = 0; i < FRM; i++) begin
            if (n % FRM == r) return;
            step();
        end
    endtask

    task automatic load(input logic [23:0] bcd, input logic [5:0] dp);
        bus.bcd_in    = bcd;
        bus.dp_in     = dp;
        bus.bcd_valid = 1'b1;
        step();
        bus.bcd_valid = 1'b0;
    endtask

    initial begin
        logic [23:0] r;
        logic [7:0]  exp_slot [6];
        logic [7:0]  lz;

        digits = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                   8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        bus.bcd_in    = '0;
        bus.dp_in     = '0;
        bus.bcd_valid = 1'b0;

        // Reset held
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", bus.seg, 8'h00);
        chk("rst_cs", {2'b00, bus.digit_cs}, 8'h3F);
        chk("rst_fd", {7'b0, bus.frame_done}, 8'h00);
        rst_n = 1'b1;
        n = 0; m_bcd = '0; m_dp = '0; m_seg = 8'h00;
        step();
        chk("first_on_cs", {2'b00, bus.digit_cs}, 8'h3E);

        // Steady frame of 012345
        load(24'h012345, 6'h00);
        repeat (FRM) step();
        exp_slot = '{8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
        for (int k = 0; k < ND; k++) begin
            goto_phase(DIV * k + 1);
            chk($sformatf("slot%0d_seg", k), bus.seg, exp_slot[k]);
        end
        goto_phase(0);
        chk("frame_pulse", {7'b0, bus.frame_done}, 8'h01);

        // Capture on the slot2 load edge
        goto_phase(2 * DIV);
        load(24'h012945, 6'h00);
        chk("same_edge_old", bus.seg, 8'h4F);
        step();
        goto_phase(2 * DIV + 1);
        chk("same_edge_new", bus.seg, 8'h6F);

        // Dash and decimal point
        load(24'h01C345, 6'b000100);
        repeat (FRM) step();
        goto_phase(2 * DIV + 1);
        chk("dp_slot2", bus.seg & 8'h80, 8'h80);
        goto_phase(3 * DIV + 1);
        chk("dash_slot3", bus.seg, 8'h40);

        // Leading zeros
        load(24'h000070, 6'h00);
        repeat (FRM) step();
`ifdef SEG7_LZB_EN
        lz = 8'h00;
`else
        lz = 8'h3F;
`endif
        goto_phase(1);
        chk("lz_slot0", bus.seg, 8'h3F);
        goto_phase(DIV + 1);
        chk("lz_slot1", bus.seg, 8'h07);
        for (int k = 2; k < ND; k++) begin
            goto_phase(DIV * k + 1);
            chk($sformatf("lz_slot%0d", k), bus.seg, lz);
        end

        // Random captures against the reference model
        for (int c = 0; c < 480; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = '0;
                for (int d = 0; d < ND; d++) begin
                    r = r << 4;
                    r[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                end
                r = r & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
                bus.bcd_in    = r;
                bus.dp_in     = 6'($urandom);
                bus.bcd_valid = 1'b1;
            end else begin
                bus.bcd_valid = 1'b0;
            end
            step();
        end
        bus.bcd_valid = 1'b0;

        // Asynchronous reset in slot3 ON phase
        load(24'h987654, 6'h3F);
        repeat (FRM) step();
        goto_phase(3 * DIV + 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_seg", bus.seg, 8'h00);
        chk("async_rst_cs", {2'b00, bus.digit_cs}, 8'h3F);
        chk("async_rst_fd", {7'b0, bus.frame_done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; m_bcd = '0; m_dp = '0; m_seg = 8'h00;
        step();
        chk("restart_slot0_cs", {2'b00, bus.digit_cs}, 8'h3E);
        chk("restart_slot0_seg", bus.seg, 8'h3F);
        repeat (2 * FRM) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
